spi_slave_mw: RTL and testbench

Parametrised SPI slave with selectable mode (CPOL/CPHA), bit order and word width. Supports multi-word frames: many back-to-back words per CS-low period. Provides a valid/ready transmit interface and a per-word receive strobe. Sits between an external MCU SPI master and the FPGA register/command logic, all in the clk domain.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_mw_if.sv | 35 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_mw.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave_mw.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the multi-word SPI slave.
package spi_pkg;

  // {CPOL, CPHA} encodings
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DEFAULT_DATA_WIDTH = 16;
  localparam int SPI_WORD_CNT_W         = 8;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_slave_mw_if.sv
// Pin and host-side bundle of the SPI slave; slave = DUT view, master = host/MCU view.
interface spi_slave_mw_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH
) ();

  logic                      spi_sck;
  logic                      spi_cs_n;
  logic                      spi_sdi;
  logic                      spi_sdo;
  logic [DATA_WIDTH-1:0]     tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic                      rx_valid;
  logic                      frame_start;
  logic                      frame_done;
  logic                      frame_err;
  logic                      tx_underrun;
  logic [SPI_WORD_CNT_W-1:0] word_cnt;

  modport slave (
    input  spi_sck, spi_cs_n, spi_sdi, tx_data, tx_valid,
    output spi_sdo, tx_ready, rx_data, rx_valid, frame_start, frame_done,
           frame_err, tx_underrun, word_cnt
  );

  modport master (
    output spi_sck, spi_cs_n, spi_sdi, tx_data, tx_valid,
    input  spi_sdo, tx_ready, rx_data, rx_valid, frame_start, frame_done,
           frame_err, tx_underrun, word_cnt
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall pulses
// derived from one history flop behind the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave_mw.sv
// SPI slave with selectable mode/bit order/width and back-to-back words per CS frame.
// state     | meaning
// ST_IDLE   | cs_n high (or not yet seen high since reset); sck ignored
// ST_ACTIVE | frame in progress; shifting words
module spi_slave_mw
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  spi_slave_mw_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sck_rise, sck_fall, sck_sync_unused;
  logic cs_rise, cs_fall, cs_sync_unused;
  logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_sck),
    .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // Reset to "selected" so a frame already in progress at reset release never
  // produces a cs fall; only a fresh high-then-low selection starts a frame.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_cs_n),
    .sync(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_sdi),
    .sync(sdi_sync), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  spi_state_e                state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]     rx_shift;
  logic [DATA_WIDTH-1:0]     shift_tx;
  logic [DATA_WIDTH-1:0]     holding;
  logic                      hold_full;
  logic                      ur_pend;
  logic                      sdo;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic                      rx_valid;
  logic                      frame_start;
  logic                      frame_done;
  logic                      frame_err;
  logic                      tx_underrun;
  logic [SPI_WORD_CNT_W-1:0] word_cnt;

  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  word_end;
  logic                  do_load;

  always_comb begin
    rx_next   = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], sdi_sync}
                          : {sdi_sync, rx_shift[DATA_WIDTH-1:1]};
    load_word = hold_full ? holding : '0;
    word_end  = (state == ST_ACTIVE) && !cs_rise && sample_edge && (bit_cnt == LAST_BIT);
    do_load   = ((state == ST_IDLE) && cs_fall) || word_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      shift_tx    <= '0;
      holding     <= '0;
      hold_full   <= 1'b0;
      ur_pend     <= 1'b0;
      sdo         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      word_cnt    <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      if (bus.tx_valid && !hold_full) begin
        holding   <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state       <= ST_ACTIVE;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rx_shift    <= '0;
            ur_pend     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_err  <= (bit_cnt != '0);
            bit_cnt    <= '0;
            ur_pend    <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            // An empty load is only reported once the master actually clocks
            // that word, so the speculative load after a frame's last word is silent.
            if (bit_cnt == '0 && ur_pend) begin
              tx_underrun <= 1'b1;
              ur_pend     <= 1'b0;
            end
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge && (CPHA || bit_cnt != '0)) begin
            sdo      <= first_bit(shift_tx);
            shift_tx <= advance(shift_tx);
          end
        end
      endcase

      if (do_load) begin
        if (hold_full) hold_full <= 1'b0;
        else           ur_pend   <= 1'b1;
        if (CPHA) begin
          shift_tx <= load_word;
        end else begin
          sdo      <= first_bit(load_word);
          shift_tx <= advance(load_word);
        end
      end
    end
  end

  assign bus.spi_sdo     = sdo;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.frame_start = frame_start;
  assign bus.frame_done  = frame_done;
  assign bus.frame_err   = frame_err;
  assign bus.tx_underrun = tx_underrun;
  assign bus.word_cnt    = word_cnt;

endmodule

// File: tb/tb_spi_slave_mw.sv
// Bench for spi_slave_mw: a mode-0/16-bit/MSB instance and a mode-3/8-bit/LSB
// instance driven by a bit-level SPI master, checked against a word-level model.
module tb_spi_slave_mw;
  import spi_pkg::*;

  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ph = 1'b0, sdi = 1'b0, cs0 = 1'b1, cs3 = 1'b1;
  logic [15:0] tx_data0 = '0;
  logic        tx_valid0 = 1'b0;
  logic [7:0]  tx_data3 = '0;
  logic        tx_valid3 = 1'b0;
  logic        acc0, acc3;

  spi_slave_mw_if #(.DATA_WIDTH(16)) bus0 ();
  spi_slave_mw_if #(.DATA_WIDTH(8))  bus3 ();

  assign bus0.spi_sck  = ph;
  assign bus0.spi_cs_n = cs0;
  assign bus0.spi_sdi  = sdi;
  assign bus0.tx_data  = tx_data0;
  assign bus0.tx_valid = tx_valid0;
  assign bus3.spi_sck  = ~ph;
  assign bus3.spi_cs_n = cs3;
  assign bus3.spi_sdi  = sdi;
  assign bus3.tx_data  = tx_data3;
  assign bus3.tx_valid = tx_valid3;

  spi_slave_mw #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(SYNC))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_slave_mw #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(SYNC))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int failures = 0;
  int rxv[2], fs[2], fd[2], fe[2], ur[2];
  logic [31:0] rxq0[$], rxq3[$], txq0[$], txq3[$];
  logic [31:0] mosi_w[$], miso_w[$], tx_w[$];
  time t_edge = 0;
  time max_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulse monitors
  initial forever begin
    @(negedge clk);
    if (bus0.rx_valid === 1'b1) begin
      rxv[0]++; rxq0.push_back(32'(bus0.rx_data));
      if ($time - t_edge > max_lat) max_lat = $time - t_edge;
    end
    if (bus3.rx_valid === 1'b1) begin
      rxv[1]++; rxq3.push_back(32'(bus3.rx_data));
      if ($time - t_edge > max_lat) max_lat = $time - t_edge;
    end
    if (bus0.frame_start === 1'b1) fs[0]++;
    if (bus3.frame_start === 1'b1) fs[1]++;
    if (bus0.frame_done === 1'b1) begin fd[0]++; if (bus0.frame_err === 1'b1) fe[0]++; end
    if (bus3.frame_done === 1'b1) begin fd[1]++; if (bus3.frame_err === 1'b1) fe[1]++; end
    if (bus0.tx_underrun === 1'b1) ur[0]++;
    if (bus3.tx_underrun === 1'b1) ur[1]++;
  end

  // tx feeders: hold tx_valid until accepted
  always @(posedge clk) begin
    acc0 <= tx_valid0 & bus0.tx_ready;
    acc3 <= tx_valid3 & bus3.tx_ready;
  end

  initial forever begin
    @(negedge clk);
    if (tx_valid0 && acc0) tx_valid0 = 1'b0;
    if (!tx_valid0 && txq0.size() > 0) begin tx_data0 = 16'(txq0.pop_front()); tx_valid0 = 1'b1; end
    if (tx_valid3 && acc3) tx_valid3 = 1'b0;
    if (!tx_valid3 && txq3.size() > 0) begin tx_data3 = 8'(txq3.pop_front()); tx_valid3 = 1'b1; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bit-level SPI master; sel 0 = mode 0/16/MSB, sel 1 = mode 3/8/LSB
  task automatic spi_frame(input int sel, input int total_bits);
    int w, wi, bi, pos;
    bit msb, cpha;
    logic b;
    logic [31:0] cur;
    w = (sel == 0) ? 16 : 8;
    msb = (sel == 0);
    cpha = (sel != 0);
    cur = '0;
    if (sel == 0) cs0 = 1'b0; else cs3 = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int n = 0; n < total_bits; n++) begin
      wi = n / w;
      bi = n % w;
      pos = msb ? (w - 1 - bi) : bi;
      b = mosi_w[wi][pos];
      if (!cpha) begin
        sdi = b;
        repeat (HALF) @(negedge clk);
        cur[pos] = (sel == 0) ? bus0.spi_sdo : bus3.spi_sdo;
        if (bi == w - 1) t_edge = $time;
        ph = 1'b1;
        repeat (HALF) @(negedge clk);
        ph = 1'b0;
      end else begin
        ph = 1'b1;
        sdi = b;
        repeat (HALF) @(negedge clk);
        cur[pos] = (sel == 0) ? bus0.spi_sdo : bus3.spi_sdo;
        if (bi == w - 1) t_edge = $time;
        ph = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      if (bi == w - 1) begin miso_w.push_back(cur); cur = '0; end
    end
    repeat (HALF) @(negedge clk);
    if (sel == 0) cs0 = 1'b1; else cs3 = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // runs a full frame of mosi_w, supplying tx_w, and checks against the word model
  task automatic frame_check(input int sel, input string tag);
    int w, nw, ntx, r0, s0, d0, e0, u0;
    logic [31:0] m, got, exp;
    w = (sel == 0) ? 16 : 8;
    m = (32'h1 << w) - 32'h1;
    nw = mosi_w.size();
    ntx = tx_w.size();
    r0 = rxv[sel]; s0 = fs[sel]; d0 = fd[sel]; e0 = fe[sel]; u0 = ur[sel];
    rxq0.delete(); rxq3.delete(); miso_w.delete();
    foreach (tx_w[i]) begin
      if (sel == 0) txq0.push_back(tx_w[i]); else txq3.push_back(tx_w[i]);
    end
    repeat (4) @(negedge clk);
    spi_frame(sel, nw * w);
    chk({tag, "_rx_count"}, 32'(rxv[sel] - r0), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      if (sel == 0) got = (k < rxq0.size()) ? rxq0[k] : 32'hDEAD_0000;
      else          got = (k < rxq3.size()) ? rxq3[k] : 32'hDEAD_0000;
      chk($sformatf("%s_rx_word%0d", tag, k), got, mosi_w[k] & m);
      got = (k < miso_w.size()) ? miso_w[k] : 32'hDEAD_0000;
      exp = (k < ntx) ? (tx_w[k] & m) : 32'h0;
      chk($sformatf("%s_miso_word%0d", tag, k), got, exp);
    end
    chk({tag, "_word_cnt"}, 32'((sel == 0) ? bus0.word_cnt : bus3.word_cnt), 32'(nw));
    chk({tag, "_underruns"}, 32'(ur[sel] - u0), 32'(nw - ntx));
    chk({tag, "_frame_start"}, 32'(fs[sel] - s0), 32'd1);
    chk({tag, "_frame_done"}, 32'(fd[sel] - d0), 32'd1);
    chk({tag, "_frame_err"}, 32'(fe[sel] - e0), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sdo0"}, 32'(bus0.spi_sdo), 32'd0);
    chk({tag, "_ready0"}, 32'(bus0.tx_ready), 32'd1);
    chk({tag, "_rxdata0"}, 32'(bus0.rx_data), 32'd0);
    chk({tag, "_pulses0"}, 32'({bus0.rx_valid, bus0.frame_start, bus0.frame_done,
                                bus0.frame_err, bus0.tx_underrun}), 32'd0);
    chk({tag, "_wcnt0"}, 32'(bus0.word_cnt), 32'd0);
    chk({tag, "_sdo3"}, 32'(bus3.spi_sdo), 32'd0);
    chk({tag, "_ready3"}, 32'(bus3.tx_ready), 32'd1);
    chk({tag, "_rxdata3"}, 32'(bus3.rx_data), 32'd0);
    chk({tag, "_wcnt3"}, 32'(bus3.word_cnt), 32'd0);
  endtask

  initial begin
    int r0, d0, e0, nw, ntx, sel;
    logic [31:0] rx_before;

    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // mode 0, MSB first, 16 bit
    mosi_w = '{32'hA5C3};
    tx_w   = '{32'h3C5A};
    frame_check(0, "m0_single");

    // mode 3, LSB first, 8 bit
    mosi_w = '{32'h81};
    tx_w   = '{32'h42};
    frame_check(1, "m3_single");

    // three-word burst fed through the handshake
    mosi_w = '{32'hAAAA, 32'h5555, 32'h0F0F};
    tx_w   = '{32'h1111, 32'h2222, 32'h3333};
    frame_check(0, "burst3");

    // two words, one tx word supplied
    mosi_w = '{32'h1357, 32'h9BDF};
    tx_w   = '{32'hBEEF};
    frame_check(0, "underrun");

    // CS rises after 5 bits
    rx_before = 32'(bus0.rx_data);
    r0 = rxv[0]; d0 = fd[0]; e0 = fe[0];
    mosi_w = '{32'hF0F0};
    txq0.push_back(32'h1234);
    repeat (4) @(negedge clk);
    miso_w.delete();
    spi_frame(0, 5);
    chk("partial_rx_count", 32'(rxv[0] - r0), 32'd0);
    chk("partial_frame_done", 32'(fd[0] - d0), 32'd1);
    chk("partial_frame_err", 32'(fe[0] - e0), 32'd1);
    chk("partial_rx_data", 32'(bus0.rx_data), rx_before);
    chk("partial_word_cnt", 32'(bus0.word_cnt), 32'd0);
    mosi_w = '{32'h6E2D};
    tx_w   = '{32'hC0DE};
    frame_check(0, "after_partial");

    // reset mid-word, remainder of frame ignored
    mosi_w = '{32'hFFFF};
    txq0.push_back(32'h7777);
    repeat (4) @(negedge clk);
    miso_w.delete();
    fork
      spi_frame(0, 16);
      begin
        repeat (HALF + 5 * 2 * HALF + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
        rst_n = 1'b1;
        r0 = rxv[0]; d0 = fd[0];
      end
    join
    chk("midrst_rx_count", 32'(rxv[0] - r0), 32'd0);
    chk("midrst_frame_done", 32'(fd[0] - d0), 32'd0);
    chk("midrst_rx_data", 32'(bus0.rx_data), 32'd0);
    mosi_w = '{32'h4B1D};
    tx_w   = '{32'hFACE};
    frame_check(0, "after_rst");

    // randomized frames on both instances
    for (int it = 0; it < 8; it++) begin
      sel = it % 2;
      nw  = int'($urandom_range(1, 4));
      ntx = int'($urandom_range(0, nw));
      mosi_w.delete();
      tx_w.delete();
      for (int k = 0; k < nw; k++) mosi_w.push_back($urandom());
      for (int k = 0; k < ntx; k++) tx_w.push_back($urandom() & ((sel == 0) ? 32'hFFFF : 32'hFF));
      frame_check(sel, $sformatf("rnd%0d", it));
    end

    chk("rx_latency_ok", 32'(max_lat <= time'((SYNC + 2) * 10)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
